bpu_port_arbiter: RTL
=====================

BPU_PORT_ARBITER -- requirements
Module: bpu_port_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, update FIFO entries (power of two, >=2).
REQ-002 Parameter STARVE_MAX, default 8, max consecutive cycles a non-empty FIFO may go without issuing an update.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 nrst  input  1  reset, synchronous, active-low.
REQ-005 lk_req  input  1  fetch-stage lookup request to the prediction table.
REQ-006 lk_idx  input  9  lookup table index (pc[10:2]).
REQ-007 lk_gnt  output  1  lookup granted the table port this cycle.
REQ-008 lk_fwd_hit  output  1  lookup index matches a pending FIFO entry.
REQ-009 lk_fwd_ctr  output  2  2-bit counter of the youngest matching pending entry.
REQ-010 upd_valid  input  1  resolved-branch update offered by the decode/execute stage.
REQ-011 upd_idx  input  9  update table index.
REQ-012 upd_ctr  input  2  new 2-bit saturating counter value.
REQ-013 upd_wtgt  input  1  also write target and alias tag.
REQ-014 upd_tgt  input  32  target address.
REQ-015 upd_tag  input  21  alias tag (pc[31:11]).
REQ-016 upd_ready  output  1  FIFO can accept an update this cycle.
REQ-017 tbl_en, tbl_we  output  1 each  table port enable and write enable.
REQ-018 tbl_addr  output  9  table port address.
REQ-019 tbl_wctr / tbl_wtgt_en / tbl_wtgt / tbl_wtag  output  2/1/32/21  write data.
REQ-020 fifo_cnt  output  3  occupancy, 0..DEPTH.

Function
REQ-021 Push occurs when upd_valid && upd_ready; upd_ready = (fifo_cnt < DEPTH), registered-state derived, no same-cycle push-on-pop when full.
REQ-022 Pushed entry becomes eligible for issue no earlier than the next cycle (no empty-FIFO bypass).
REQ-023 Each cycle exactly one of {lookup, update, idle} owns the port.
REQ-024 Update issues (pops head) when FIFO non-empty and (lk_req==0 or fifo_cnt==DEPTH or starve_force==1); otherwise lookup wins.
REQ-025 lk_gnt = lk_req && !update_issue, combinational.
REQ-026 On lookup: tbl_en=1, tbl_we=0, tbl_addr=lk_idx; on update: tbl_en=1, tbl_we=1, tbl_addr and write data from FIFO head; idle: tbl_en=0, tbl_we=0, tbl_addr=0.
REQ-027 lk_fwd_hit=1 only when lk_gnt=1 and a valid entry (including one being pushed this cycle excluded) matches lk_idx; lk_fwd_ctr is youngest match's ctr, else 0.
REQ-028 Simultaneous push and pop: fifo_cnt unchanged, ordering preserved (strict FIFO).
REQ-029 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-030 With DEPTH full and lk_req=1, update issues and lk_gnt=0 for that cycle.

Reset
REQ-031 While nrst=0 at posedge: FIFO empty, pointers 0, fifo_cnt=0, starve counter 0, all entries invalid.
REQ-032 Reset asserted mid-operation discards pending updates; first cycle after reset upd_ready=1, tbl_en=lk_req.

Configuration
REQ-033 Macro BPU_ARB_STARVE_EN compiles in the starvation guard.
REQ-034 Defined: counter increments each cycle FIFO is non-empty and no update issues, clears on issue or empty; starve_force=1 when counter == STARVE_MAX-1.
REQ-035 Undefined: starve_force tied 0, no counter; updates issue only on idle lookup or full FIFO.

Verification
REQ-036 Reset, lk_req=1 idx=0x05 -> lk_gnt=1, tbl_addr=0x05, tbl_we=0, fifo_cnt=0.
REQ-037 Push idx=0x10 ctr=2'b11 with lk_req=0 -> next cycle tbl_we=1, tbl_addr=0x10, tbl_wctr=2'b11, fifo_cnt 1->0.
REQ-038 lk_req held 1, push 4 updates -> upd_ready=0 at cnt 4, next cycle update issues, lk_gnt=0, cnt=3.
REQ-039 Pending entries idx=0x20 ctr=01 then idx=0x20 ctr=10, lookup idx=0x20 -> lk_fwd_hit=1, lk_fwd_ctr=2'b10.
REQ-040 BPU_ARB_STARVE_EN defined, one entry, lk_req held 1 -> update issues on 8th cycle after push becomes eligible; undefined -> never issues.

Source files
------------

// File: rtl/bpu_port_arbiter.sv
// Shares the branch prediction table port between fetch lookups and queued updates.
// Define BPU_ARB_STARVE_EN to build in the update starvation guard.
module bpu_port_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                       clk,
   input  logic                       nrst,
   input  logic                       lk_req,
   input  logic [8:0]                 lk_idx,
   output logic                       lk_gnt,
   output logic                       lk_fwd_hit,
   output logic [1:0]                 lk_fwd_ctr,
   input  logic                       upd_valid,
   input  logic [8:0]                 upd_idx,
   input  logic [1:0]                 upd_ctr,
   input  logic                       upd_wtgt,
   input  logic [31:0]                upd_tgt,
   input  logic [20:0]                upd_tag,
   output logic                       upd_ready,
   output logic                       tbl_en,
   output logic                       tbl_we,
   output logic [8:0]                 tbl_addr,
   output logic [1:0]                 tbl_wctr,
   output logic                       tbl_wtgt_en,
   output logic [31:0]                tbl_wtgt,
   output logic [20:0]                tbl_wtag,
   output logic [$clog2(DEPTH):0]     fifo_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DEPTH < 2 || STARVE_MAX < 1) begin : g_bad_param
      $error("bpu_port_arbiter: bad parameters");
   end

   logic [8:0]       e_idx  [DEPTH];
   logic [1:0]       e_ctr  [DEPTH];
   logic             e_wtgt [DEPTH];
   logic [31:0]      e_tgt  [DEPTH];
   logic [20:0]      e_tag  [DEPTH];
   logic [DEPTH-1:0] e_vld;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic [CW-1:0]    cnt;

   logic push;
   logic pop;
   logic non_empty;
   logic full;
   logic starve_force;
   logic fwd_hit_c;
   logic [1:0] fwd_ctr_c;
   logic [AW-1:0] p;

   assign full      = (cnt == CW'(DEPTH));
   assign non_empty = (cnt != '0);
   assign upd_ready = ~full;
   assign push      = upd_valid & upd_ready;
   assign pop       = non_empty & (~lk_req | full | starve_force);
   assign lk_gnt    = lk_req & ~pop;
   assign fifo_cnt  = cnt;

`ifdef BPU_ARB_STARVE_EN
   localparam int SW = $clog2(STARVE_MAX + 1);
   logic [SW-1:0] starve_cnt;

   assign starve_force = (starve_cnt == SW'(STARVE_MAX - 1));

   always_ff @(posedge clk) begin
      if (!nrst)
         starve_cnt <= '0;
      else if (non_empty && !pop)
         starve_cnt <= starve_cnt + SW'(1);
      else
         starve_cnt <= '0;
   end
`else
   assign starve_force = 1'b0;
`endif

   // Walk oldest to youngest so the last match is the youngest entry.
   always_comb begin
      fwd_hit_c = 1'b0;
      fwd_ctr_c = 2'b00;
      p         = '0;
      for (int i = 0; i < DEPTH; i++) begin
         p = rd_ptr + AW'(i);
         if (e_vld[p] && e_idx[p] == lk_idx) begin
            fwd_hit_c = 1'b1;
            fwd_ctr_c = e_ctr[p];
         end
      end
   end

   assign lk_fwd_hit = lk_gnt & fwd_hit_c;
   assign lk_fwd_ctr = lk_fwd_hit ? fwd_ctr_c : 2'b00;

   assign tbl_en      = lk_gnt | pop;
   assign tbl_we      = pop;
   assign tbl_addr    = pop ? e_idx[rd_ptr] : (lk_gnt ? lk_idx : 9'd0);
   assign tbl_wctr    = pop ? e_ctr[rd_ptr] : 2'b00;
   assign tbl_wtgt_en = pop & e_wtgt[rd_ptr];
   assign tbl_wtgt    = pop ? e_tgt[rd_ptr] : 32'd0;
   assign tbl_wtag    = pop ? e_tag[rd_ptr] : 21'd0;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         e_vld  <= '0;
      end else begin
         if (push) begin
            e_vld[wr_ptr] <= 1'b1;
            wr_ptr        <= wr_ptr + AW'(1);
         end
         if (pop) begin
            e_vld[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + AW'(1);
         end
         if (push && !pop)
            cnt <= cnt + CW'(1);
         else if (pop && !push)
            cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         e_idx[wr_ptr]  <= upd_idx;
         e_ctr[wr_ptr]  <= upd_ctr;
         e_wtgt[wr_ptr] <= upd_wtgt;
         e_tgt[wr_ptr]  <= upd_tgt;
         e_tag[wr_ptr]  <= upd_tag;
      end
   end

endmodule
